// File: rtl/led_sched.sv
// Memory-mapped LED scheduler: register window, display mode FSM and LED register write strobes.
// Optional feature: define LEDSCH_ROTATE_EN to enable ROTATE mode (MODE = 2).
module led_sched #(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF_F000,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50_000_000
) (
  input  logic        ledsch_clk,
  input  logic        ledsch_rst,
  input  logic [31:0] ledsch_addr,
  input  logic        ledsch_we,
  input  logic [31:0] ledsch_wdata,
  output logic [31:0] ledsch_rdata,
  output logic        ledsch_busy,
  output logic        ledsch_led_we,
  output logic [31:0] ledsch_led_wdata
);

  // ledsch_led_we is a one-cycle valid qualifying ledsch_led_wdata; the LED
  // register has no ready and accepts every strobe in the cycle it is shown.

  typedef enum logic [1:0] {
    S_STATIC = 2'd0,
    S_ON     = 2'd1,
    S_OFF    = 2'd2
  } state_t;

  localparam logic [1:0] MODE_BLINK  = 2'd1;
`ifdef LEDSCH_ROTATE_EN
  localparam logic [1:0] MODE_ROTATE = 2'd2;
`endif

  state_t      state_q, state_d;
  logic [15:0] pattern_q, pattern_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] cur_q, cur_d;
  logic        led_we_q, led_we_d;
  logic [15:0] led_data_q, led_data_d;

  logic wr_pattern, wr_mode, wr_period;
  logic running, tick;
  logic mode_periodic;

  assign wr_pattern = ledsch_we && (ledsch_addr == BASE_ADDR);
  assign wr_mode    = ledsch_we && (ledsch_addr == BASE_ADDR + 32'h4);
  assign wr_period  = ledsch_we && (ledsch_addr == BASE_ADDR + 32'h8);

  assign running = (state_q != S_STATIC) && (period_q != 32'd0);
  assign tick    = running && (cnt_q == period_q - 32'd1);

  // Modes that run the periodic sequencer; everything else displays statically.
`ifdef LEDSCH_ROTATE_EN
  assign mode_periodic = (ledsch_wdata[1:0] == MODE_BLINK) ||
                         (ledsch_wdata[1:0] == MODE_ROTATE);
`else
  assign mode_periodic = (ledsch_wdata[1:0] == MODE_BLINK);
`endif

  always_ff @(posedge ledsch_clk or posedge ledsch_rst) begin
    if (ledsch_rst) begin
      state_q    <= S_STATIC;
      pattern_q  <= 16'h0000;
      mode_q     <= 2'd0;
      period_q   <= DEFAULT_PERIOD;
      cnt_q      <= 32'd0;
      cur_q      <= 16'h0000;
      led_we_q   <= 1'b0;
      led_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      mode_q     <= mode_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      led_we_q   <= led_we_d;
      led_data_q <= led_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    mode_d     = mode_q;
    period_d   = period_q;
    cur_d      = cur_q;
    led_we_d   = 1'b0;
    led_data_d = led_data_q;

    if (!running || tick) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    // A CPU write always takes priority; a coincident tick is dropped.
    if (wr_pattern) begin
      pattern_d  = ledsch_wdata[15:0];
      cur_d      = ledsch_wdata[15:0];
      cnt_d      = 32'd0;
      led_we_d   = 1'b1;
      led_data_d = ledsch_wdata[15:0];
      if (state_q == S_OFF) begin
        state_d = S_ON;
      end
    end else if (wr_mode) begin
      mode_d     = ledsch_wdata[1:0];
      cur_d      = pattern_q;
      cnt_d      = 32'd0;
      state_d    = mode_periodic ? S_ON : S_STATIC;
      led_we_d   = 1'b1;
      led_data_d = pattern_q;
    end else if (wr_period) begin
      period_d = ledsch_wdata;
      cnt_d    = 32'd0;
    end else if (tick) begin
      case (state_q)
        S_ON: begin
          if (mode_q == MODE_BLINK) begin
            state_d    = S_OFF;
            led_we_d   = 1'b1;
            led_data_d = 16'h0000;
          end
`ifdef LEDSCH_ROTATE_EN
          else if (mode_q == MODE_ROTATE) begin
            cur_d      = {cur_q[14:0], cur_q[15]};
            led_we_d   = 1'b1;
            led_data_d = {cur_q[14:0], cur_q[15]};
          end
`endif
        end
        S_OFF: begin
          state_d    = S_ON;
          led_we_d   = 1'b1;
          led_data_d = pattern_q;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    ledsch_rdata = 32'd0;
    if (ledsch_addr == BASE_ADDR) begin
      ledsch_rdata = {16'h0000, pattern_q};
    end else if (ledsch_addr == BASE_ADDR + 32'h4) begin
      ledsch_rdata = {30'd0, mode_q};
    end else if (ledsch_addr == BASE_ADDR + 32'h8) begin
      ledsch_rdata = period_q;
    end else if (ledsch_addr == BASE_ADDR + 32'hC) begin
      ledsch_rdata = {16'h0000, cur_q};
    end
  end

  assign ledsch_busy      = running;
  assign ledsch_led_we    = led_we_q;
  assign ledsch_led_wdata = {16'h0000, led_data_q};

endmodule

// File: tb/tb_led_sched.sv
// Scoreboard bench for led_sched: strobes are expected as {edge index, data} in a queue.
// Build with LEDSCH_ROTATE_EN defined to exercise the rotate expectations.
module tb_led_sched;

  localparam logic [31:0] BASE = 32'hFFFF_F000;
  localparam logic [31:0] PER  = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        busy;
  logic        led_we;
  logic [31:0] led_wdata;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  led_sched #(
    .BASE_ADDR(BASE),
    .DEFAULT_PERIOD(PER)
  ) dut (
    .ledsch_clk(clk),
    .ledsch_rst(rst),
    .ledsch_addr(addr),
    .ledsch_we(we),
    .ledsch_wdata(wdata),
    .ledsch_rdata(rdata),
    .ledsch_busy(busy),
    .ledsch_led_we(led_we),
    .ledsch_led_wdata(led_wdata)
  );

  // Clock / edge index: after rising edge k, cyc == k.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every strobe pops one expectation.
  always @(negedge clk) begin
    if (!rst && led_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: got cyc=%0d data=%h, required no strobe", cyc, led_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e != {32'(cyc), led_wdata}) begin
          errors++;
          $display("FAIL strobe: got cyc=%0d data=%h, required cyc=%0d data=%h",
                   cyc, led_wdata, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  function automatic void expect_strobe(input int e, input logic [15:0] d);
    exp_q.push_back({32'(e), 16'h0000, d});
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d strobes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Drive a write sampled at edge e (no earlier than at_edge); we drops at the next driver step.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int at_edge, output int e);
    @(negedge clk);
    we = 1'b0;
    while (cyc + 1 < at_edge) @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    e     = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      we = 1'b0;
    end
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(negedge clk);
      we = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] req, input string name);
    @(negedge clk);
    we   = 1'b0;
    addr = a;
    #1;
    check(name, rdata, req);
  endtask

  initial begin
    int e, e2, e3, em, p;

    // Reset and idle.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(20);
    check("rst_led_wdata", led_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rd(BASE,         32'd0, "rst_pattern");
    rd(BASE + 32'h4, 32'd0, "rst_mode");
    rd(BASE + 32'h8, PER,   "rst_period");
    rd(BASE + 32'hC, 32'd0, "rst_cur");

    // Unmapped write is ignored and reads 0.
    wr(BASE + 32'h10, 32'h0000_FFFF, 0, e);
    idle(3);
    rd(BASE + 32'h10, 32'd0, "unmapped_read");
    rd(BASE,          32'd0, "unmapped_no_effect");

    // Static mode: one strobe per pattern write.
    wr(BASE, 32'h0000_00A5, 0, e);
    expect_strobe(e, 16'h00A5);
    idle(20);
    drain("static_pattern");
    check("static_busy", 32'(busy), 32'd0);
    rd(BASE + 32'hC, 32'h0000_00A5, "static_cur");

    // Blink with period 4.
    wr(BASE, 32'h0000_00FF, 0, e);
    expect_strobe(e, 16'h00FF);
    wr(BASE + 32'h4, 32'd1, 0, e2);
    expect_strobe(e2,      16'h00FF);
    expect_strobe(e2 + 4,  16'h0000);
    expect_strobe(e2 + 8,  16'h00FF);
    expect_strobe(e2 + 12, 16'h0000);
    idle(1);
    check("blink_busy", 32'(busy), 32'd1);

    // Pattern write on the exact tick edge: write wins, toggles restart.
    wr(BASE, 32'h0000_000F, e2 + 16, e3);
    check("collide_edge", 32'(e3), 32'(e2 + 16));
    expect_strobe(e3,     16'h000F);
    expect_strobe(e3 + 4, 16'h0000);
    expect_strobe(e3 + 8, 16'h000F);

    // Period 0 freezes the display.
    wr(BASE + 32'h8, 32'd0, e3 + 10, e);
    idle(1);
    check("period0_busy", 32'(busy), 32'd0);
    idle(20);
    drain("blink");
    check("period0_hold", led_wdata, 32'h0000_000F);
    rd(BASE + 32'hC, 32'h0000_000F, "period0_cur");

    // Nonzero period resumes from count 0.
    wr(BASE + 32'h8, PER, 0, p);
    expect_strobe(p + 4, 16'h0000);
    wr(BASE + 32'h4, 32'd0, p + 6, e);
    expect_strobe(e, 16'h000F);
    idle(20);
    drain("resume");
    check("resume_busy", 32'(busy), 32'd0);

    // Rotate mode (static when the feature is not built).
    wr(BASE, 32'h0000_8001, 0, e);
    expect_strobe(e, 16'h8001);
    wr(BASE + 32'h4, 32'd2, 0, em);
    expect_strobe(em, 16'h8001);
`ifdef LEDSCH_ROTATE_EN
    expect_strobe(em + 4, 16'h0003);
    expect_strobe(em + 8, 16'h0006);
    idle(1);
    check("rot_busy", 32'(busy), 32'd1);
    rd(BASE + 32'h4, 32'd2, "rot_mode");
    wait_until(em + 9);
    rd(BASE + 32'hC, 32'h0000_0006, "rot_cur");
`else
    idle(1);
    check("rot_busy", 32'(busy), 32'd0);
    rd(BASE + 32'h4, 32'd2, "rot_mode");
    idle(20);
    rd(BASE + 32'hC, 32'h0000_8001, "rot_cur");
`endif
    wr(BASE + 32'h4, 32'd0, 0, e);
    expect_strobe(e, 16'h8001);
    idle(20);
    drain("rotate");

    // Reset in the middle of blinking.
    wr(BASE, 32'h0000_003C, 0, e);
    expect_strobe(e, 16'h003C);
    wr(BASE + 32'h4, 32'd1, 0, em);
    expect_strobe(em,     16'h003C);
    expect_strobe(em + 4, 16'h0000);
    wait_until(em + 4);
    #1;
    drain("pre_reset");
    rst = 1'b1;
    #1;
    check("async_rst_led_we", 32'(led_we), 32'd0);
    check("async_rst_led_wdata", led_wdata, 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    idle(3);
    rst = 1'b0;
    idle(20);
    rd(BASE + 32'h4, 32'd0, "post_rst_mode");
    rd(BASE,         32'd0, "post_rst_pattern");
    rd(BASE + 32'h8, PER,   "post_rst_period");
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_sched.md
# led_sched

Memory-mapped LED controller between the CPU store port and the LED output register. Decodes a small register window, holds the programmed pattern and a display mode, and sequences single-cycle write strobes to the LED register: once per software update in static mode, periodically in blink/rotate mode. Replaces direct CPU writes to the LED register, which then takes its write strobe and data only from this block.

## Interface
- BASE_ADDR, 32'hFFFF_F000, base of the 16-byte register window
- DEFAULT_PERIOD, 32'd50_000_000, PERIOD register value after reset (ticks in clock cycles)

- ledsch_clk  input  1  clock
- ledsch_rst  input  1  asynchronous, active-high reset
- ledsch_addr  input  32  CPU byte address
- ledsch_we  input  1  CPU write strobe, one cycle per store
- ledsch_wdata  input  32  CPU write data
- ledsch_rdata  output  32  combinational readback of addressed register
- ledsch_busy  output  1  high while in a periodic mode with PERIOD != 0
- ledsch_led_we  output  1  registered write strobe to LED register
- ledsch_led_wdata  output  32  registered data to LED register; [31:16] always 0

## Operation
- Registers (exact address match; other addresses ignored for write, read 0):
  - +0x0 PATTERN [15:0]; +0x4 MODE [1:0]: 0 STATIC, 1 BLINK, 2 ROTATE, 3 treated as STATIC; +0x8 PERIOD [31:0]; +0xC CUR (read-only, {16'b0, displayed value}).
- Internal: pattern[15:0], mode[1:0], period[31:0], cnt[31:0], cur[15:0], state ∈ {S_STATIC, S_ON, S_OFF}.
- Write PATTERN: pattern, cur ← wdata[15:0]; cnt ← 0; S_OFF → S_ON; emit strobe with new pattern.
- Write MODE: mode ← wdata[1:0]; cnt ← 0; cur ← pattern; state ← S_STATIC (mode 0/3) or S_ON (1/2); emit strobe with pattern.
- Write PERIOD: period ← wdata; cnt ← 0; no strobe.
- Tick: state ≠ S_STATIC, period ≠ 0, cnt == period−1 → cnt ← 0; else cnt ← cnt+1. In S_STATIC or period == 0, cnt held at 0.
- On tick: BLINK toggles S_ON↔S_OFF, emits pattern (entering S_ON) or 16'h0000 (entering S_OFF). ROTATE: cur ← {cur[14:0], cur[15]}, emits new cur; state stays S_ON.
- Simultaneous CPU write and tick: write wins; tick discarded; cnt ← 0.
- PERIOD set to 0 while running: ticks stop, display held, busy drops; nonzero PERIOD resumes from cnt 0.
- busy = (state ≠ S_STATIC) && (period ≠ 0).

## Timing
- Reset values: ledsch_led_we 0, ledsch_led_wdata 0, ledsch_busy 0, pattern 0, mode 0, period DEFAULT_PERIOD, cnt 0, cur 0, state S_STATIC. No strobe on reset release.
- CPU write sampled at edge N → ledsch_led_we high for exactly the cycle after edge N, data valid same cycle.
- Tick condition true in cycle before edge N → strobe after edge N. Periodic updates spaced exactly PERIOD cycles; PERIOD = 1 gives a strobe every cycle.
- First periodic strobe after a PATTERN/MODE/PERIOD write follows PERIOD cycles after the write edge.
- ledsch_rdata combinational on ledsch_addr, reflects register state after the last edge.
- Reset asserted mid-sequence clears all state immediately; strobe deasserts asynchronously.

## Configuration
- LEDSCH_ROTATE_EN defined: ROTATE mode (MODE = 2) as above.
- Undefined: rotate logic omitted; MODE = 2 is stored and read back as 2 but behaves as STATIC (state S_STATIC, no ticks, busy 0).

## Test plan
- Reset, then hold 20 cycles → led_we never high, led_wdata 0, busy 0, reads: PERIOD = DEFAULT_PERIOD, others 0.
- DEFAULT_PERIOD=4; write PATTERN 0x00A5 → one strobe, data 0x000000A5, next cycle; no further strobes over 20 cycles.
- PATTERN 0x00FF, MODE 1 → strobe 0x00FF, then 0x0000, 0x00FF, 0x0000 every 4 cycles; busy 1.
- With LEDSCH_ROTATE_EN: PATTERN 0x8001, MODE 2 → strobe 0x8001, then 0x0003, 0x0006 every 4 cycles; CUR reads 0x0006. Without macro: single strobe 0x8001, busy 0.
- BLINK running, PATTERN write on exact tick cycle → only the write strobe issued, next toggle 4 cycles later; PERIOD 0 → no strobes, busy 0.
- Assert reset mid-BLINK → led_we, led_wdata, busy 0 immediately; after release, no strobes, MODE reads 0.
